// File: rtl/counter_seq_ctrl.sv
// Command-driven up-counter with a prescaled tick, programmable terminal value,
// one-shot or periodic operation and a pause/resume capability.
module counter_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             mode_periodic,
    input  logic [DIV_W-1:0] prescale,
    output logic             cmd_ready,
    output logic [WIDTH-1:0] count,
    output logic             done,
    output logic             busy,
    output logic [1:0]       state,
    output logic             cmd_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] tc_q, tc_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic is_start, is_stop, is_load;
    logic tick, terminal;

    // Always ready whenever reset is released; no back-pressure exists.
    assign cmd_ready = reset;

    assign is_start = cmd_valid && (cmd_op == OP_START);
    assign is_stop  = cmd_valid && (cmd_op == OP_STOP);
    assign is_load  = cmd_valid && (cmd_op == OP_LOAD);

    assign tick     = (state_q == ST_RUN) && (presc_q >= prescale);
    assign terminal = tick && (count_q == tc_q);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = tc_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_RUN: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                err_d   = is_start || is_load;
                if (terminal) begin
                    done_d = 1'b1;
                    if (mode_periodic) begin
                        count_d = '0;
                        state_d = is_stop ? ST_PAUSE : ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (is_stop) begin
                    // Stop wins over a plain tick: the count freezes where it was.
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    count_d = count_q + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (is_load) begin
                    tc_d = cmd_data;
                end else if (is_start) begin
                    state_d = ST_RUN;
                end else if (is_stop) begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                // IDLE and DONE share restart/load handling; STOP only matters in DONE.
                if (is_load) begin
                    tc_d = cmd_data;
                end else if (is_start) begin
                    count_d = '0;
                    presc_d = '0;
                    state_d = ST_RUN;
                end else if (is_stop && (state_q == ST_DONE)) begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end
            end
        endcase

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            tc_q    <= '1;
            presc_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            presc_q <= presc_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign count   = count_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign state   = state_q;
    assign cmd_err = err_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed scenarios plus randomized commands checked cycle by cycle against
// a behavioural model of the counter's command rules.
module tb_counter_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic       mode_periodic;
    logic [3:0] prescale;
    logic       cmd_ready;
    logic [3:0] count;
    logic       done;
    logic       busy;
    logic [1:0] state;
    logic       cmd_err;

    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;
    localparam logic [1:0] NOP = 2'd0, START = 2'd1, STOP = 2'd2, LOAD = 2'd3;

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    int m_state, m_count, m_tc, m_presc;
    bit m_done, m_err;

    counter_seq_ctrl #(.WIDTH(4), .DIV_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .mode_periodic(mode_periodic),
        .prescale     (prescale),
        .cmd_ready    (cmd_ready),
        .count        (count),
        .done         (done),
        .busy         (busy),
        .state        (state),
        .cmd_err      (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, want, $time);
        end
    endtask

    function automatic void model_reset();
        m_state = S_IDLE; m_count = 0; m_tc = 15; m_presc = 0;
        m_done = 0; m_err = 0;
    endfunction

    // One rising edge of the counter's behaviour, from the command rules.
    function automatic void model_step();
        int  op;
        bit  tick;
        op = cmd_valid ? int'(cmd_op) : 0;
        m_done = 0;
        m_err  = 0;
        if (m_state == S_RUN) begin
            tick = (m_presc >= int'(prescale));
            m_presc = tick ? 0 : (m_presc + 1) % 16;
            m_err = (op == START) || (op == LOAD);
            if (tick && m_count == m_tc) begin
                m_done = 1;
                if (mode_periodic) begin
                    m_count = 0;
                    m_state = (op == STOP) ? S_PAUSE : S_RUN;
                end else begin
                    m_state = S_DONE;
                end
            end else if (op == STOP) begin
                m_state = S_PAUSE;
            end else if (tick) begin
                m_count = (m_count + 1) % 16;
            end
        end else begin
            if (op == LOAD) begin
                m_tc = int'(cmd_data);
            end else if (op == START) begin
                if (m_state != S_PAUSE) begin
                    m_count = 0;
                    m_presc = 0;
                end
                m_state = S_RUN;
            end else if (op == STOP && m_state != S_IDLE) begin
                m_count = 0;
                m_state = S_IDLE;
            end
        end
    endfunction

    task automatic compare_all(input string pfx);
        chk({pfx, "_count"}, 32'(count), 32'(m_count));
        chk({pfx, "_state"}, 32'(state), 32'(m_state));
        chk({pfx, "_done"},  32'(done),  32'(m_done));
        chk({pfx, "_err"},   32'(cmd_err), 32'(m_err));
        chk({pfx, "_busy"},  32'(busy),  32'(m_state == S_RUN));
        chk({pfx, "_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic reset_values(input string pfx);
        chk({pfx, "_rst_ready"}, 32'(cmd_ready), 32'd0);
        chk({pfx, "_rst_state"}, 32'(state), 32'd0);
        chk({pfx, "_rst_count"}, 32'(count), 32'd0);
        chk({pfx, "_rst_done"},  32'(done), 32'd0);
        chk({pfx, "_rst_busy"},  32'(busy), 32'd0);
        chk({pfx, "_rst_err"},   32'(cmd_err), 32'd0);
    endtask

    // Drive one command, clock it in, advance the model and compare everything.
    task automatic cyc(input logic v, input logic [1:0] op, input logic [3:0] d);
        cmd_valid = v;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge clk);
        model_step();
        #1;
        compare_all("cyc");
        @(negedge clk);
    endtask

    // Assert reset between edges, check immediate reset values, then release.
    task automatic mid_cycle_reset(input string pfx);
        #2;
        reset = 1'b0;
        #1;
        reset_values(pfx);
        model_reset();
        @(posedge clk);
        #1;
        reset_values({pfx, "_held"});
        @(negedge clk);
        reset = 1'b1;
    endtask

    int seq035 [6] = '{0, 0, 1, 1, 2, 2};

    initial begin
        reset = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = NOP;
        cmd_data = '0;
        mode_periodic = 1'b0;
        prescale = '0;
        model_reset();
        #3;
        reset_values("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // LOAD 3, one-shot, prescale 0
        cyc(1, LOAD, 4'd3);
        cyc(1, START, 0);
        chk("r34_c0", 32'(count), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            cyc(0, NOP, 0);
            chk("r34_seq", 32'(count), 32'(i));
            chk("r34_nodone", 32'(done), 32'd0);
        end
        cyc(0, NOP, 0);
        chk("r34_done", 32'(done), 32'd1);
        chk("r34_state", 32'(state), 32'(S_DONE));
        cyc(0, NOP, 0);
        chk("r34_done_once", 32'(done), 32'd0);
        chk("r34_hold", 32'(count), 32'd3);

        // LOAD 2, periodic, prescale 1
        mode_periodic = 1'b1;
        prescale = 4'd1;
        cyc(1, LOAD, 4'd2);
        cyc(1, START, 0);
        for (int k = 1; k <= 12; k++) begin
            cyc(0, NOP, 0);
            chk("r35_count", 32'(count), 32'(seq035[k % 6]));
            chk("r35_done", 32'(done), 32'(k % 6 == 0));
        end

        // pause / resume / stop to idle
        cyc(1, STOP, 0);
        cyc(1, STOP, 0);
        mode_periodic = 1'b0;
        prescale = 4'd0;
        cyc(1, LOAD, 4'd5);
        cyc(1, START, 0);
        cyc(0, NOP, 0);
        cyc(0, NOP, 0);
        chk("r36_run2", 32'(count), 32'd2);
        cyc(1, STOP, 0);
        chk("r36_pause_st", 32'(state), 32'(S_PAUSE));
        chk("r36_pause_cnt", 32'(count), 32'd2);
        cyc(1, START, 0);
        chk("r36_resume_st", 32'(state), 32'(S_RUN));
        cyc(0, NOP, 0);
        chk("r36_resume_cnt", 32'(count), 32'd3);
        cyc(1, STOP, 0);
        cyc(1, STOP, 0);
        chk("r36_idle_st", 32'(state), 32'(S_IDLE));
        chk("r36_idle_cnt", 32'(count), 32'd0);

        // commands rejected while running
        cyc(1, START, 0);
        cyc(0, NOP, 0);
        cyc(1, LOAD, 4'd1);
        chk("r37_load_err", 32'(cmd_err), 32'd1);
        cyc(0, NOP, 0);
        chk("r37_err_pulse", 32'(cmd_err), 32'd0);
        cyc(0, NOP, 0);
        cyc(0, NOP, 0);
        chk("r37_cnt5", 32'(count), 32'd5);
        cyc(0, NOP, 0);
        chk("r37_tc_kept", 32'(done), 32'd1);
        cyc(1, START, 0);
        cyc(0, NOP, 0);
        cyc(1, START, 0);
        chk("r37_start_err", 32'(cmd_err), 32'd1);
        chk("r37_no_clear", 32'(count), 32'd2);

        // STOP on the terminal tick, periodic
        cyc(1, STOP, 0);
        cyc(1, STOP, 0);
        mode_periodic = 1'b1;
        cyc(1, LOAD, 4'd1);
        cyc(1, START, 0);
        cyc(0, NOP, 0);
        cyc(1, STOP, 0);
        chk("r38_done", 32'(done), 32'd1);
        chk("r38_count", 32'(count), 32'd0);
        chk("r38_state", 32'(state), 32'(S_PAUSE));

        // asynchronous reset in the middle of a run
        cyc(1, START, 0);
        cyc(0, NOP, 0);
        mid_cycle_reset("r39");
        mode_periodic = 1'b0;
        cyc(0, NOP, 0);
        chk("r39_idle", 32'(state), 32'(S_IDLE));
        chk("r39_nodone", 32'(done), 32'd0);
        cyc(1, START, 0);
        for (int i = 0; i < 15; i++) cyc(0, NOP, 0);
        chk("r39_cnt15", 32'(count), 32'd15);
        cyc(0, NOP, 0);
        chk("r39_tc15_done", 32'(done), 32'd1);

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 7) == 0) prescale = 4'($urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0) mode_periodic = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) begin
                mid_cycle_reset("rnd");
            end else begin
                cyc(1'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 5)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
